// File: rtl/triangle_seq.sv
// rtl/triangle_seq.sv - triangle draw sequencer (clear, three circle segments); optional CLEAR via TRIANGLE_SEQ_CLEAR_EN
module triangle_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  diameter,
    input  logic [2:0]  colour,
    output logic        fill_start,
    input  logic        fill_done,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic        fill_plot,
    output logic        seg_start,
    input  logic        seg_done,
    output logic [1:0]  seg_type,
    output logic [9:0]  seg_cx,
    output logic [9:0]  seg_cy,
    output logic [7:0]  seg_radius,
    input  logic [9:0]  seg_x,
    input  logic [9:0]  seg_y,
    input  logic        seg_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_BLUE, S_GREEN, S_RED, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cx_q;
    logic [6:0]  cy_q;
    logic [7:0]  d_q;
    logic [2:0]  colour_q;
    logic        engine_live;
    logic        seg_state;

    logic [15:0]       prod1, prod2;
    logic signed [9:0] h1, h2, r, cxs, cys;
    logic signed [9:0] x1, y1, x2, y2, x3, y3;
    logic signed [9:0] sx, sy;
    logic              on_screen, in_window;

`ifndef TRIANGLE_SEQ_CLEAR_EN
    logic unused_fill;
    assign unused_fill = &{1'b0, fill_done, fill_x, fill_y, fill_plot};
`endif

    // corner geometry from the latched operands, all signed 10-bit
    assign prod1 = {8'b0, d_q} * 16'd74;
    assign prod2 = {8'b0, d_q} * 16'd148;
    assign h1    = $signed({2'b00, prod1[15:8]});
    assign h2    = $signed({2'b00, prod2[15:8]});
    assign r     = $signed({3'b000, d_q[7:1]});
    assign cxs   = $signed({2'b00, cx_q});
    assign cys   = $signed({3'b000, cy_q});
    assign x1    = cxs + r;
    assign y1    = cys + h1;
    assign x2    = cxs - r;
    assign y2    = cys + h1;
    assign x3    = cxs;
    assign y3    = cys - h2;

    assign sx        = $signed(seg_x);
    assign sy        = $signed(seg_y);
    assign on_screen = (sx >= 10'sd0) && (sx <= 10'sd159) && (sy >= 10'sd0) && (sy <= 10'sd119);
    assign seg_state = (state == S_BLUE) || (state == S_GREEN) || (state == S_RED);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // engine request goes live after the first cycle of an engine state, drops on exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) engine_live <= 1'b0;
        else     engine_live <= (state_nx == state) &&
                                (seg_state || (state == S_CLEAR));
    end

    // operand capture during LOAD only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q     <= '0;
            cy_q     <= '0;
            d_q      <= '0;
            colour_q <= '0;
        end else if (state == S_LOAD) begin
            cx_q     <= centre_x;
            cy_q     <= centre_y;
            d_q      <= diameter;
            colour_q <= colour;
        end
    end

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
`ifdef TRIANGLE_SEQ_CLEAR_EN
            S_LOAD:  state_nx = S_CLEAR;
            S_CLEAR: if (fill_done) state_nx = S_BLUE;
`else
            S_LOAD:  state_nx = S_BLUE;
`endif
            S_BLUE:  if (seg_done) state_nx = S_GREEN;
            S_GREEN: if (seg_done) state_nx = S_RED;
            S_RED:   if (seg_done) state_nx = S_DONE;
            S_DONE:  if (!start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // engine requests, segment parameters and pixel mux
    always_comb begin
        done       = (state == S_DONE);
        fill_start = 1'b0;
        seg_start  = seg_state && engine_live;
        seg_type   = 2'd0;
        seg_cx     = '0;
        seg_cy     = '0;
        seg_radius = seg_state ? d_q : 8'd0;
        in_window  = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (state)
`ifdef TRIANGLE_SEQ_CLEAR_EN
            S_CLEAR: begin
                fill_start = engine_live;
                vga_x      = fill_x;
                vga_y      = fill_y;
                vga_plot   = fill_plot;
            end
`endif
            S_BLUE: begin
                seg_type  = 2'd0;
                seg_cx    = x1;
                seg_cy    = y1;
                in_window = (sx <= x3);
            end
            S_GREEN: begin
                seg_type  = 2'd1;
                seg_cx    = x2;
                seg_cy    = y2;
                in_window = (sx >= x3);
            end
            S_RED: begin
                seg_type  = 2'd2;
                seg_cx    = x3;
                seg_cy    = y3;
                in_window = (sx >= x2) && (sx <= x1);
            end
            default: ;
        endcase
        if (seg_state) begin
            vga_x      = seg_x[7:0];
            vga_y      = seg_y[6:0];
            vga_colour = colour_q;
            vga_plot   = seg_plot && on_screen && in_window;
        end
    end

endmodule

// File: tb/tb_triangle_seq.sv
// tb/tb_triangle_seq.sv - directed self-checking bench for triangle_seq
module tb_triangle_seq;

    logic        clk = 1'b0;
    logic        rst, start, done;
    logic [7:0]  centre_x, diameter;
    logic [6:0]  centre_y;
    logic [2:0]  colour;
    logic        fill_start, fill_done, fill_plot;
    logic [7:0]  fill_x;
    logic [6:0]  fill_y;
    logic        seg_start, seg_done, seg_plot;
    logic [1:0]  seg_type;
    logic [9:0]  seg_cx, seg_cy, seg_x, seg_y;
    logic [7:0]  seg_radius;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int n_cmp = 0;
    int n_err = 0;

    triangle_seq dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter), .colour(colour),
        .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
        .fill_plot(fill_plot),
        .seg_start(seg_start), .seg_done(seg_done), .seg_type(seg_type),
        .seg_cx(seg_cx), .seg_cy(seg_cy), .seg_radius(seg_radius),
        .seg_x(seg_x), .seg_y(seg_y), .seg_plot(seg_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (done && (seg_start || fill_start || vga_plot)) begin
                n_err++;
                $error("FAIL inv_done_quiet seg_start=%0d fill_start=%0d vga_plot=%0d",
                       seg_start, fill_start, vga_plot);
            end
            n_cmp++;
            if (seg_start && fill_start) begin
                n_err++;
                $error("FAIL inv_one_engine");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".done"}, 32'(done), 32'(0));
        chk({tag, ".fill_start"}, 32'(fill_start), 32'(0));
        chk({tag, ".seg_start"}, 32'(seg_start), 32'(0));
        chk({tag, ".seg_type"}, 32'(seg_type), 32'(0));
        chk({tag, ".seg_cx"}, 32'(seg_cx), 32'(0));
        chk({tag, ".seg_cy"}, 32'(seg_cy), 32'(0));
        chk({tag, ".seg_radius"}, 32'(seg_radius), 32'(0));
        chk({tag, ".vga"}, 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(0));
    endtask

    task automatic pass_clear();
`ifdef TRIANGLE_SEQ_CLEAR_EN
        chk("clr_first_fill_start", 32'(fill_start), 32'(0));
        step();
        chk("clr_fill_start", 32'(fill_start), 32'(1));
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        centre_x = '0; centre_y = '0; diameter = '0; colour = '0;
        fill_done = 1'b0; fill_x = '0; fill_y = '0; fill_plot = 1'b0;
        seg_done = 1'b0; seg_x = '0; seg_y = '0; seg_plot = 1'b0;
        #12;
        all_zero("reset");
        step();
        rst = 1'b0;

        fill_plot = 1'b1; seg_plot = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_done", 32'(done), 32'(0));
            chk("idle_seg_start", 32'(seg_start), 32'(0));
            chk("idle_vga_plot", 32'(vga_plot), 32'(0));
        end
        fill_plot = 1'b0; seg_plot = 1'b0;

        centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80; colour = 3'b010;
        start = 1'b1;
        step();
        chk("load_seg_start", 32'(seg_start), 32'(0));
        chk("load_vga_plot", 32'(vga_plot), 32'(0));
        step();
        centre_x = 8'd0; centre_y = 7'd0; diameter = 8'd0; colour = 3'b111;
`ifdef TRIANGLE_SEQ_CLEAR_EN
        fill_x = 8'd5; fill_y = 7'd6; fill_plot = 1'b1;
        #1;
        chk("clr_vga_x", 32'(vga_x), 32'(5));
        chk("clr_vga_y", 32'(vga_y), 32'(6));
        chk("clr_vga_colour", 32'(vga_colour), 32'(0));
        chk("clr_vga_plot", 32'(vga_plot), 32'(1));
        fill_plot = 1'b0;
`endif
        pass_clear();
        chk("blue_first_seg_start", 32'(seg_start), 32'(0));
        chk("blue_fill_start", 32'(fill_start), 32'(0));
        chk("blue_cx", 32'(seg_cx), 32'(120));
        chk("blue_cy", 32'(seg_cy), 32'(83));
        chk("blue_type", 32'(seg_type), 32'(0));
        chk("blue_radius", 32'(seg_radius), 32'(80));
        step();
        chk("blue_seg_start", 32'(seg_start), 32'(1));
        start = 1'b0; fill_done = 1'b1;
        seg_plot = 1'b1; seg_x = 10'd80; seg_y = 10'd50;
        #1;
        chk("blue_win_in", 32'(vga_plot), 32'(1));
        chk("blue_vga_x", 32'(vga_x), 32'(80));
        chk("blue_vga_y", 32'(vga_y), 32'(50));
        chk("blue_vga_colour", 32'(vga_colour), 32'(2));
        seg_x = 10'd81;
        #1;
        chk("blue_win_out", 32'(vga_plot), 32'(0));
        step();
        fill_done = 1'b0;
        chk("blue_hold_cx", 32'(seg_cx), 32'(120));
        chk("blue_hold_start", 32'(seg_start), 32'(1));
        seg_done = 1'b1;
        step();
        seg_done = 1'b0;
        chk("green_first_seg_start", 32'(seg_start), 32'(0));
        chk("green_cx", 32'(seg_cx), 32'(40));
        chk("green_cy", 32'(seg_cy), 32'(83));
        chk("green_type", 32'(seg_type), 32'(1));
        step();
        chk("green_seg_start", 32'(seg_start), 32'(1));
        seg_x = 10'd75; seg_y = 10'd50;
        #1;
        chk("green_x75", 32'(vga_plot), 32'(0));
        seg_x = 10'd170;
        #1;
        chk("green_x170", 32'(vga_plot), 32'(0));
        seg_x = 10'd90;
        #1;
        chk("green_x90", 32'(vga_plot), 32'(1));
        chk("green_colour", 32'(vga_colour), 32'(2));
        chk("green_vga_x", 32'(vga_x), 32'(90));
        seg_y = 10'd120;
        #1;
        chk("green_y120", 32'(vga_plot), 32'(0));
        seg_done = 1'b1;
        step();
        seg_done = 1'b0;
        chk("red_cx", 32'(seg_cx), 32'(80));
        chk("red_cy", 32'(seg_cy), 32'(14));
        chk("red_type", 32'(seg_type), 32'(2));
        chk("red_first_seg_start", 32'(seg_start), 32'(0));
        step();
        chk("red_seg_start", 32'(seg_start), 32'(1));
        seg_y = 10'd50; seg_x = 10'd40;
        #1;
        chk("red_x40", 32'(vga_plot), 32'(1));
        seg_x = 10'd120;
        #1;
        chk("red_x120", 32'(vga_plot), 32'(1));
        seg_x = 10'd121;
        #1;
        chk("red_x121", 32'(vga_plot), 32'(0));
        seg_x = 10'd39;
        #1;
        chk("red_x39", 32'(vga_plot), 32'(0));
        start = 1'b1; seg_done = 1'b1;
        step();
        seg_done = 1'b0;
        chk("done_set", 32'(done), 32'(1));
        chk("done_seg_start", 32'(seg_start), 32'(0));
        chk("done_vga_plot", 32'(vga_plot), 32'(0));
        step();
        chk("done_hold", 32'(done), 32'(1));
        start = 1'b0;
        step();
        chk("done_cleared", 32'(done), 32'(0));
        seg_plot = 1'b0;

        centre_x = 8'd10; centre_y = 7'd20; diameter = 8'd0; colour = 3'b101;
        start = 1'b1;
        step();
        step();
        pass_clear();
        chk("d0_blue_cx", 32'(seg_cx), 32'(10));
        chk("d0_blue_cy", 32'(seg_cy), 32'(20));
        chk("d0_radius", 32'(seg_radius), 32'(0));
        step();
        seg_done = 1'b1;
        step();
        seg_done = 1'b0;
        chk("d0_green_cx", 32'(seg_cx), 32'(10));
        step();
        seg_done = 1'b1;
        step();
        seg_done = 1'b0;
        chk("d0_red_cy", 32'(seg_cy), 32'(20));
        chk("d0_red_type", 32'(seg_type), 32'(2));
        step();
        chk("d0_red_seg_start", 32'(seg_start), 32'(1));
        seg_plot = 1'b1; seg_y = 10'd30; seg_x = 10'd10;
        #1;
        chk("d0_red_x10", 32'(vga_plot), 32'(1));
        seg_x = 10'd11;
        #1;
        chk("d0_red_x11", 32'(vga_plot), 32'(0));
        seg_plot = 1'b0;
        centre_x = 8'd100; centre_y = 7'd50; diameter = 8'd40;
        #1;
        rst = 1'b1;
        #1;
        all_zero("rst_red");
        step();
        chk("rst_hold_seg_start", 32'(seg_start), 32'(0));
        rst = 1'b0;
        step();
        chk("reload_seg_start", 32'(seg_start), 32'(0));
        chk("reload_seg_cx", 32'(seg_cx), 32'(0));
        step();
        pass_clear();
        chk("reload_blue_cx", 32'(seg_cx), 32'(120));
        chk("reload_blue_cy", 32'(seg_cy), 32'(61));
        chk("reload_radius", 32'(seg_radius), 32'(40));
        chk("reload_first_start", 32'(seg_start), 32'(0));
        step();
        chk("reload_seg_start", 32'(seg_start), 32'(1));
        rst = 1'b1; start = 1'b0;
        #1;
        all_zero("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
